// File: rtl/regset_sequencer_if.sv
// Command handshake and shared-bus signals between the regset sequencer and its environment.
// The sequencer takes the slave side; the command source / bus owner takes the master side.
interface regset_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             i_cmdValid;
    logic             o_cmdReady;
    logic [2:0]       i_cmdOp;
    logic [WIDTH-1:0] i_cmdImm;
    logic [WIDTH-1:0] i_bus;
    logic [WIDTH-1:0] o_busImm;
    logic             o_busImmNOE;
    logic             o_busReq;
    logic             i_busGrant;

    modport slave (
        input  i_cmdValid, i_cmdOp, i_cmdImm, i_bus, i_busGrant,
        output o_cmdReady, o_busImm, o_busImmNOE, o_busReq
    );

    modport master (
        output i_cmdValid, i_cmdOp, i_cmdImm, i_bus, i_busGrant,
        input  o_cmdReady, o_busImm, o_busImmNOE, o_busReq
    );
endinterface

// File: rtl/regset_sequencer.sv
// Command sequencer for the two-register set: turns one-shot commands into ordered
// write-enable / bus-driver strobes, gated by the shared-bus grant.
module regset_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    regset_sequencer_if.slave   bus_if,
    output logic                o_ctrlReg0NWE,
    output logic                o_ctrlReg1NWE,
    output logic                o_ctrlAluSel,
    output logic                o_ctrlRegBusSel,
    output logic                o_ctrlRegBusNOE,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EX1  = 2'd1,
        ST_EX2  = 2'd2,
        ST_EX3  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LDI0  = 3'b000;
    localparam logic [2:0] OP_LDI1  = 3'b001;
    localparam logic [2:0] OP_MOV01 = 3'b010;
    localparam logic [2:0] OP_MOV10 = 3'b011;
    localparam logic [2:0] OP_SWAP  = 3'b100;
    localparam logic [2:0] OP_ASEL0 = 3'b101;
    localparam logic [2:0] OP_ASEL1 = 3'b110;
    localparam logic [2:0] OP_CLR   = 3'b111;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] temp_q, temp_d;
    logic             alu_sel_q, alu_sel_d;

    logic             imm_noe;
    logic             reg_bus_noe;
    logic             reg_bus_sel;
    logic             reg0_nwe;
    logic             reg1_nwe;
    logic [WIDTH-1:0] bus_imm;
    logic             done;

    // State, latched command, swap temp and ALU select registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            op_q      <= 3'b000;
            imm_q     <= {WIDTH{1'b0}};
            temp_q    <= {WIDTH{1'b0}};
            alu_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            imm_q     <= imm_d;
            temp_q    <= temp_d;
            alu_sel_q <= alu_sel_d;
        end
    end

    // Next-state and strobe decode; strobes only leave their idle level in a granted EX cycle
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        imm_d       = imm_q;
        temp_d      = temp_q;
        alu_sel_d   = alu_sel_q;
        imm_noe     = 1'b1;
        reg_bus_noe = 1'b1;
        reg_bus_sel = 1'b0;
        reg0_nwe    = 1'b1;
        reg1_nwe    = 1'b1;
        bus_imm     = {WIDTH{1'b0}};
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.i_cmdValid) begin
                    case (bus_if.i_cmdOp)
                        OP_ASEL0: alu_sel_d = 1'b0;
                        OP_ASEL1: alu_sel_d = 1'b1;
                        default: begin
                            op_d    = bus_if.i_cmdOp;
                            imm_d   = bus_if.i_cmdImm;
                            state_d = ST_EX1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EX1: begin
                if (bus_if.i_busGrant) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                    case (op_q)
                        OP_LDI0: begin
                            bus_imm  = imm_q;
                            imm_noe  = 1'b0;
                            reg0_nwe = 1'b0;
                        end
                        OP_LDI1: begin
                            bus_imm  = imm_q;
                            imm_noe  = 1'b0;
                            reg1_nwe = 1'b0;
                        end
                        OP_MOV01: begin
                            reg_bus_sel = 1'b0;
                            reg_bus_noe = 1'b0;
                            reg1_nwe    = 1'b0;
                        end
                        OP_MOV10: begin
                            reg_bus_sel = 1'b1;
                            reg_bus_noe = 1'b0;
                            reg0_nwe    = 1'b0;
                        end
                        OP_CLR: begin
                            bus_imm  = {WIDTH{1'b0}};
                            imm_noe  = 1'b0;
                            reg0_nwe = 1'b0;
                            reg1_nwe = 1'b0;
                        end
                        OP_SWAP: begin
                            // r_0 goes onto the bus and is parked in temp for EX3
                            reg_bus_sel = 1'b0;
                            reg_bus_noe = 1'b0;
                            temp_d      = bus_if.i_bus;
                            state_d     = ST_EX2;
                            done        = 1'b0;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_EX1;
                end
            end
            ST_EX2: begin
                if (bus_if.i_busGrant) begin
                    reg_bus_sel = 1'b1;
                    reg_bus_noe = 1'b0;
                    reg0_nwe    = 1'b0;
                    state_d     = ST_EX3;
                end else begin
                    state_d = ST_EX2;
                end
            end
            ST_EX3: begin
                if (bus_if.i_busGrant) begin
                    bus_imm  = temp_q;
                    imm_noe  = 1'b0;
                    reg1_nwe = 1'b0;
                    done     = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_EX3;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_if.o_cmdReady  = (state_q == ST_IDLE);
    assign bus_if.o_busReq    = (state_q != ST_IDLE);
    assign bus_if.o_busImm    = bus_imm;
    assign bus_if.o_busImmNOE = imm_noe;

    assign o_busy          = (state_q != ST_IDLE);
    assign o_done          = done;
    assign o_ctrlReg0NWE   = reg0_nwe;
    assign o_ctrlReg1NWE   = reg1_nwe;
    assign o_ctrlAluSel    = alu_sel_q;
    assign o_ctrlRegBusSel = reg_bus_sel;
    assign o_ctrlRegBusNOE = reg_bus_noe;

endmodule

// File: doc/regset_sequencer.md
Name: regset_sequencer

Overview:
- Command-driven controller for the two-register set (r_0/r_1). It turns one-shot commands into correctly ordered control strobes: the active-low write enables, the ALU select, the bus-source select and the bus output enable.
- It owns an immediate bus driver and an internal temp register, so it can also do immediate loads, register moves, clear and a three-cycle swap.
- It requests the shared 8-bit bus from the system arbiter and never drives the bus without a grant.

Parameters:
- WIDTH, 8, data width of bus, immediate and temp register.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_cmdValid  in  1  command present.
- o_cmdReady  out  1  sequencer can accept a command.
- i_cmdOp  in  3  opcode, see Behaviour.
- i_cmdImm  in  WIDTH  immediate for LDI0/LDI1.
- i_bus  in  WIDTH  shared bus value, sampled for the swap temp capture.
- o_busImm  out  WIDTH  immediate/temp value for the external tri-state driver.
- o_busImmNOE  out  1  active-low enable of the immediate driver.
- o_busReq  out  1  bus request to the arbiter.
- i_busGrant  in  1  bus granted this cycle.
- o_ctrlReg0NWE  out  1  active-low write of r_0.
- o_ctrlReg1NWE  out  1  active-low write of r_1.
- o_ctrlAluSel  out  1  ALU operand select (0=r_0, 1=r_1).
- o_ctrlRegBusSel  out  1  register driven to bus (0=r_0, 1=r_1).
- o_ctrlRegBusNOE  out  1  active-low enable of the register-set bus driver.
- o_busy  out  1  a command is executing.
- o_done  out  1  one-cycle pulse in the final execute cycle of a command.

Behaviour:
- Opcodes:
  - 000 LDI0: imm -> r_0.
  - 001 LDI1: imm -> r_1.
  - 010 MOV01: r_0 -> r_1.
  - 011 MOV10: r_1 -> r_0.
  - 100 SWAP: exchange r_0 and r_1.
  - 101 ASEL0: ALU select <= 0.
  - 110 ASEL1: ALU select <= 1.
  - 111 CLR: 0 -> r_0 and r_1.
- States: IDLE, EX1, EX2, EX3. State, latched op, latched imm and temp register are all cleared by i_reset.
- Reset values (asynchronous, effective immediately):
  - state=IDLE.
  - o_cmdReady=1.
  - all NWE/NOE outputs=1.
  - o_ctrlAluSel=0, o_ctrlRegBusSel=0.
  - o_busImm=0, o_busReq=0, o_busy=0, o_done=0.
  - temp=0.
- Accept rule: a command is accepted at the rising edge where i_cmdValid & o_cmdReady. o_cmdReady = (state==IDLE).
  - ASEL0/ASEL1: update the o_ctrlAluSel register at the accept edge and stay in IDLE. No bus use, no o_done. Back-to-back accepts are allowed.
  - All other ops: latch op and imm, go to EX1.
- o_busy = o_busReq = (state!=IDLE).
- Stall: while in an EX state with i_busGrant=0, the state holds and all NWE/NOE outputs are forced to 1. Strobes may assert only in cycles where i_busGrant=1; an execute step completes only on such a cycle.
- Execute steps (all listed strobes asserted low in that granted cycle):
  - LDI0, EX1: o_busImm=imm, busImmNOE, Reg0NWE. Then IDLE.
  - LDI1, EX1: o_busImm=imm, busImmNOE, Reg1NWE. Then IDLE.
  - MOV01, EX1: RegBusSel=0, RegBusNOE, Reg1NWE.
  - MOV10, EX1: RegBusSel=1, RegBusNOE, Reg0NWE.
  - CLR, EX1: o_busImm=0, busImmNOE, Reg0NWE and Reg1NWE.
  - SWAP, EX1: RegBusSel=0, RegBusNOE; temp <= i_bus at the edge.
  - SWAP, EX2: RegBusSel=1, RegBusNOE, Reg0NWE.
  - SWAP, EX3: o_busImm=temp, busImmNOE, Reg1NWE. Then IDLE.
- Latency: single-step ops take 2 cycles accept-to-ready with no stalls; SWAP takes 4.
- o_done=1 during the final granted execute cycle.
- Invariant: o_busImmNOE and o_ctrlRegBusNOE are never both 0. Both are 1 in IDLE and during stalls.
- Outputs are decoded from registered state, op and grant only; they do not depend on i_cmdValid.
- Reset mid-command aborts it: no further strobes, and temp is lost. Register contents already written are kept.
- i_cmdOp/i_cmdImm changes after acceptance have no effect.
- Grant present while the sequencer is IDLE: ignored.

Test Plan:
- Reset released, then LDI0 imm=0x5A with grant held 1 -> the cycle after accept has busImmNOE=0, o_busImm=0x5A, Reg0NWE=0 and o_done=1; the next cycle o_cmdReady=1; the regset model holds r_0=0x5A.
- With r_0=0x12 and r_1=0x34, issue SWAP with grant=1 -> temp captures 0x12 in EX1; r_0=0x34 after EX2; r_1=0x12 after EX3; exactly 3 strobe cycles; no NOE overlap in any cycle.
- MOV01 with i_busGrant=0 for 3 cycles, then 1 -> busy/busReq stay high with all strobes 1 for those 3 cycles; a single Reg1NWE pulse follows and r_1 equals r_0.
- Issue ASEL1 then ASEL0 on consecutive edges -> o_ctrlAluSel goes 1 then 0, o_cmdReady stays 1, o_busReq never rises.
- Assert i_reset asynchronously during SWAP EX2 -> all NWE/NOE go 1 immediately without waiting for a clock; state is IDLE; o_ctrlAluSel=0; r_1 is unmodified.
- CLR with r_0=0xFF and r_1=0xAA -> one granted cycle with both NWE low and o_busImm=0; both registers read 0x00.
